// File: rtl/wb_unit_pkg.sv
// Shared definitions for the writeback stage: data width, register address
// width, RV32I load funct3 encodings, load-queue entry type and the load
// byte/half extraction helper.
package wb_unit_pkg;

    localparam int MXLEN      = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [MXLEN-1:0]      data;
    } ldq_entry_t;

    // Select the addressed byte/half of the raw memory word and extend it.
    // Any funct3 that is not a byte or half load returns the full word.
    function automatic logic [MXLEN-1:0] load_extract(
        input logic [2:0]       funct3,
        input logic [1:0]       addr_lo,
        input logic [MXLEN-1:0] data
    );
        logic [7:0]       byte_sel;
        logic [15:0]      half_sel;
        logic [MXLEN-1:0] result;
        case (addr_lo)
            2'd0:    byte_sel = data[7:0];
            2'd1:    byte_sel = data[15:8];
            2'd2:    byte_sel = data[23:16];
            default: byte_sel = data[31:24];
        endcase
        half_sel = addr_lo[1] ? data[31:16] : data[15:0];
        case (funct3)
            F3_LB:   result = {{(MXLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  result = {{(MXLEN-8){1'b0}}, byte_sel};
            F3_LH:   result = {{(MXLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  result = {{(MXLEN-16){1'b0}}, half_sel};
            default: result = data;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/wb_ldq.sv
// Load-response holding queue: synchronous FIFO of {rd, data} entries with
// an occupancy count driving the full/empty flags. Pushes while full and
// pops while empty are ignored.
module wb_ldq
    import wb_unit_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       push,
    input  ldq_entry_t push_data,
    input  logic       pop,
    output ldq_entry_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    ldq_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage array; contents are only meaningful between pointers, so no reset.
    always_ff @(posedge CLK) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_unit.sv
// Writeback stage: merges ALU results and queued load responses into one
// registered register-file write per cycle, and tracks outstanding loads in
// a per-register scoreboard for RAW hazard detection.
// Optional macro WB_BYPASS_EN adds byp_data1/2 and byp_hit1/2 forwarding
// outputs from the registered write port.
module wb_unit
    import wb_unit_pkg::*;
#(
    parameter int LDQ_DEPTH = 2,
    parameter int REG_NUM   = 32
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  exception,
    input  logic                  iss_valid,
    input  logic [REG_ADDR_W-1:0] iss_rd,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [MXLEN-1:0]      alu_data,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [REG_ADDR_W-1:0] ld_rd,
    input  logic [2:0]            ld_funct3,
    input  logic [1:0]            ld_addr_lo,
    input  logic [MXLEN-1:0]      ld_data,
    input  logic [REG_ADDR_W-1:0] r_addr1,
    input  logic [REG_ADDR_W-1:0] r_addr2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  reg_write,
    output logic [REG_ADDR_W-1:0] w_addr,
    output logic [MXLEN-1:0]      w_data
`ifdef WB_BYPASS_EN
    ,
    output logic [MXLEN-1:0]      byp_data1,
    output logic [MXLEN-1:0]      byp_data2,
    output logic                  byp_hit1,
    output logic                  byp_hit2
`endif
);

    logic         alu_win;
    logic         ldq_push;
    logic         ldq_pop;
    logic         ldq_full;
    logic         ldq_empty;
    ldq_entry_t   push_entry;
    ldq_entry_t   ldq_head;
    logic [REG_NUM-1:0] busy;
    logic [REG_NUM-1:0] busy_nxt;

    // An exception kills the ALU result; the queue only drains on ALU-idle cycles.
    assign alu_win    = alu_valid && !exception;
    assign ld_ready   = !ldq_full;
    assign ldq_push   = ld_valid && ld_ready;
    assign ldq_pop    = !alu_win && !ldq_empty;
    assign push_entry = '{rd: ld_rd, data: load_extract(ld_funct3, ld_addr_lo, ld_data)};

    wb_ldq #(
        .DEPTH (LDQ_DEPTH)
    ) u_ldq (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .push      (ldq_push),
        .push_data (push_entry),
        .pop       (ldq_pop),
        .head      (ldq_head),
        .full      (ldq_full),
        .empty     (ldq_empty)
    );

    // Registered write port: ALU first, then queue head; address/data hold when idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            reg_write <= 1'b0;
            w_addr    <= '0;
            w_data    <= '0;
        end else if (alu_win) begin
            reg_write <= 1'b1;
            w_addr    <= alu_rd;
            w_data    <= alu_data;
        end else if (!ldq_empty) begin
            reg_write <= 1'b1;
            w_addr    <= ldq_head.rd;
            w_data    <= ldq_head.data;
        end else begin
            reg_write <= 1'b0;
        end
    end

    // Scoreboard next state: the clear from a pop is applied first so a
    // same-cycle reissue of that register leaves it busy.
    always_comb begin
        busy_nxt = busy;
        if (ldq_pop) begin
            busy_nxt[ldq_head.rd] = 1'b0;
        end
        if (iss_valid && !exception && (iss_rd != '0)) begin
            busy_nxt[iss_rd] = 1'b1;
        end
    end

    // Scoreboard register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            busy <= '0;
        end else begin
            busy <= busy_nxt;
        end
    end

    assign hazard1 = busy[r_addr1] && (r_addr1 != '0);
    assign hazard2 = busy[r_addr2] && (r_addr2 != '0);

`ifdef WB_BYPASS_EN
    assign byp_hit1  = reg_write && (w_addr == r_addr1) && (r_addr1 != '0);
    assign byp_hit2  = reg_write && (w_addr == r_addr2) && (r_addr2 != '0);
    assign byp_data1 = byp_hit1 ? w_data : '0;
    assign byp_data2 = byp_hit2 ? w_data : '0;
`endif

endmodule

// File: tb/tb_wb_unit.sv
// Self-checking bench for wb_unit: table-driven load extension vectors,
// hand-written multi-cycle sequences, and a randomized phase checked
// against a queue-based reference model.
module tb_wb_unit;

    localparam int LDQ_DEPTH = 2;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        exception;
    logic        iss_valid;
    logic [4:0]  iss_rd;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        ld_valid;
    logic        ld_ready;
    logic [4:0]  ld_rd;
    logic [2:0]  ld_funct3;
    logic [1:0]  ld_addr_lo;
    logic [31:0] ld_data;
    logic [4:0]  r_addr1;
    logic [4:0]  r_addr2;
    logic        hazard1;
    logic        hazard2;
    logic        reg_write;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
`ifdef WB_BYPASS_EN
    logic [31:0] byp_data1;
    logic [31:0] byp_data2;
    logic        byp_hit1;
    logic        byp_hit2;
`endif

    wb_unit #(.LDQ_DEPTH(LDQ_DEPTH), .REG_NUM(32)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .exception  (exception),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .alu_valid  (alu_valid),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_funct3  (ld_funct3),
        .ld_addr_lo (ld_addr_lo),
        .ld_data    (ld_data),
        .r_addr1    (r_addr1),
        .r_addr2    (r_addr2),
        .hazard1    (hazard1),
        .hazard2    (hazard2),
        .reg_write  (reg_write),
        .w_addr     (w_addr),
        .w_data     (w_data)
`ifdef WB_BYPASS_EN
        ,
        .byp_data1  (byp_data1),
        .byp_data2  (byp_data2),
        .byp_hit1   (byp_hit1),
        .byp_hit2   (byp_hit2)
`endif
    );

    always #5 CLK = ~CLK;

    int passed = 0;
    int total  = 0;

    // Reference model state: pending load writes in arrival order, busy flags,
    // and the expected registered write port.
    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ment_t;
    ment_t       mq[$];
    bit [31:0]   busy_m;
    logic        exp_we;
    logic [4:0]  exp_wa;
    logic [31:0] exp_wd;

    typedef struct {
        logic [2:0]  f3;
        logic [1:0]  off;
        logic [31:0] exp;
    } lvec_t;
    lvec_t tbl[10];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [31:0] ref_extract(input logic [2:0] f3, input logic [1:0] off,
                                                input logic [31:0] d);
        logic [31:0] v;
        case (f3)
            3'b000, 3'b100: begin
                v = (d >> (8 * off)) & 32'hFF;
                if (f3 == 3'b000 && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                v = (d >> (16 * off[1])) & 32'hFFFF;
                if (f3 == 3'b001 && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = d;
        endcase
        return v;
    endfunction

    task automatic model_reset();
        mq.delete();
        busy_m = '0;
        exp_we = 1'b0;
        exp_wa = '0;
        exp_wd = '0;
    endtask

    task automatic model_step();
        bit    alu_w;
        bit    rdy;
        ment_t e;
        alu_w = alu_valid && !exception;
        rdy   = mq.size() < LDQ_DEPTH;
        if (alu_w) begin
            exp_we = 1'b1; exp_wa = alu_rd; exp_wd = alu_data;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = 1'b1; exp_wa = e.rd; exp_wd = e.data;
            busy_m[e.rd] = 1'b0;
        end else begin
            exp_we = 1'b0;
        end
        if (ld_valid && rdy) begin
            e.rd   = ld_rd;
            e.data = ref_extract(ld_funct3, ld_addr_lo, ld_data);
            mq.push_back(e);
        end
        if (iss_valid && !exception && iss_rd != 5'd0) busy_m[iss_rd] = 1'b1;
    endtask

    // One clock: check combinational outputs, advance model, check registered outputs.
    task automatic cycle();
        #1;
        check("ld_ready", 32'(ld_ready), 32'(mq.size() < LDQ_DEPTH));
        check("hazard1", 32'(hazard1), 32'(busy_m[r_addr1] && r_addr1 != 5'd0));
        check("hazard2", 32'(hazard2), 32'(busy_m[r_addr2] && r_addr2 != 5'd0));
        model_step();
        @(posedge CLK);
        #1;
        check("reg_write", 32'(reg_write), 32'(exp_we));
        check("w_addr", 32'(w_addr), 32'(exp_wa));
        check("w_data", w_data, exp_wd);
    endtask

    task automatic idle_inputs();
        exception = 0; iss_valid = 0; iss_rd = 0; alu_valid = 0; alu_rd = 0; alu_data = 0;
        ld_valid = 0; ld_rd = 0; ld_funct3 = 0; ld_addr_lo = 0; ld_data = 0;
    endtask

    initial begin
        int hz;
        tbl[0] = '{3'b000, 2'd3, 32'hFFFF_FF80};
        tbl[1] = '{3'b100, 2'd1, 32'h0000_007F};
        tbl[2] = '{3'b001, 2'd2, 32'hFFFF_80FF};
        tbl[3] = '{3'b101, 2'd0, 32'h0000_7F01};
        tbl[4] = '{3'b010, 2'd1, 32'h80FF_7F01};
        tbl[5] = '{3'b011, 2'd0, 32'h80FF_7F01};
        tbl[6] = '{3'b000, 2'd2, 32'hFFFF_FFFF};
        tbl[7] = '{3'b100, 2'd3, 32'h0000_0080};
        tbl[8] = '{3'b101, 2'd2, 32'h0000_80FF};
        tbl[9] = '{3'b001, 2'd0, 32'h0000_7F01};

        idle_inputs();
        r_addr1 = 0; r_addr2 = 0;
        RST_N = 1'b0;
        model_reset();
        #3;
        check("rst_reg_write", 32'(reg_write), 32'd0);
        check("rst_w_addr", 32'(w_addr), 32'd0);
        check("rst_w_data", w_data, 32'd0);
        check("rst_ld_ready", 32'(ld_ready), 32'd1);
        @(posedge CLK); #1;
        RST_N = 1'b1;

        // ALU write, then the same write killed by an exception
        alu_valid = 1; alu_rd = 5; alu_data = 32'h1234_5678;
        cycle();
        check("alu_we", 32'(reg_write), 32'd1);
        check("alu_addr", 32'(w_addr), 32'd5);
        check("alu_data", w_data, 32'h1234_5678);
        exception = 1;
        cycle();
        check("alu_exc_we", 32'(reg_write), 32'd0);
        idle_inputs();

        // Load extension table
        for (int i = 0; i < 10; i++) begin
            ld_valid = 1; ld_rd = 5'(20 + i); ld_funct3 = tbl[i].f3;
            ld_addr_lo = tbl[i].off; ld_data = 32'h80FF_7F01;
            cycle();
            ld_valid = 0;
            cycle();
            check("ext_we", 32'(reg_write), 32'd1);
            check("ext_data", w_data, tbl[i].exp);
        end

        // Contention: three ALU cycles while loads arrive; third load is held off
        alu_valid = 1; alu_rd = 1; alu_data = 32'h111;
        ld_valid = 1; ld_rd = 10; ld_funct3 = 3'b010; ld_addr_lo = 0; ld_data = 32'hAAAA_0001;
        cycle();
        check("cont_alu1", 32'(w_addr), 32'd1);
        alu_rd = 2; alu_data = 32'h222; ld_rd = 11; ld_data = 32'hBBBB_0002;
        cycle();
        check("cont_alu2", 32'(w_addr), 32'd2);
        alu_rd = 3; alu_data = 32'h333; ld_rd = 12; ld_data = 32'hCCCC_0003;
        #1;
        check("cont_full", 32'(ld_ready), 32'd0);
        cycle();
        check("cont_alu3", 32'(w_addr), 32'd3);
        idle_inputs();
        cycle();
        check("cont_ld1_addr", 32'(w_addr), 32'd10);
        check("cont_ld1_data", w_data, 32'hAAAA_0001);
        cycle();
        check("cont_ld2_addr", 32'(w_addr), 32'd11);
        check("cont_ld2_data", w_data, 32'hBBBB_0002);
        cycle();
        check("cont_idle", 32'(reg_write), 32'd0);

        // Scoreboard: set, reissue in pop cycle, final clear, rd=0 issue
        r_addr1 = 7;
        iss_valid = 1; iss_rd = 7;
        cycle();
        iss_valid = 0;
        #1;
        check("sb_set", 32'(hazard1), 32'd1);
        ld_valid = 1; ld_rd = 7; ld_funct3 = 3'b010; ld_data = 32'h0707_0707;
        cycle();
        ld_valid = 0;
        #1;
        check("sb_queued", 32'(hazard1), 32'd1);
        iss_valid = 1; iss_rd = 7;
        cycle();
        iss_valid = 0;
        #1;
        check("sb_reissue_wb", 32'(w_addr), 32'd7);
        check("sb_reissue", 32'(hazard1), 32'd1);
        ld_valid = 1; ld_rd = 7; ld_data = 32'h7777_7777;
        cycle();
        ld_valid = 0;
        cycle();
        #1;
        check("sb_clear", 32'(hazard1), 32'd0);
        iss_valid = 1; iss_rd = 0; r_addr1 = 0;
        cycle();
        iss_valid = 0;
        #1;
        check("sb_rd0", 32'(hazard1), 32'd0);

`ifdef WB_BYPASS_EN
        alu_valid = 1; alu_rd = 9; alu_data = 32'hAA;
        cycle();
        alu_valid = 0;
        r_addr2 = 9;
        #1;
        check("byp_hit2", 32'(byp_hit2), 32'd1);
        check("byp_data2", byp_data2, 32'hAA);
        r_addr2 = 0;
        #1;
        check("byp_hit2_r0", 32'(byp_hit2), 32'd0);
        check("byp_data2_r0", byp_data2, 32'd0);
`endif

        // Reset mid-stream with two loads queued and scoreboard bits set
        for (int i = 0; i < 3; i++) begin
            alu_valid = 1; alu_rd = 5'(i + 1); alu_data = 32'(i);
            ld_valid = (i < 2); ld_rd = 5'(4 + 2 * i); ld_funct3 = 3'b010; ld_data = 32'(100 + i);
            iss_valid = 1; iss_rd = 5'(4 + 2 * i);
            cycle();
        end
        idle_inputs();
        RST_N = 1'b0;
        #1;
        model_reset();
        check("mrst_reg_write", 32'(reg_write), 32'd0);
        check("mrst_ld_ready", 32'(ld_ready), 32'd1);
        hz = 0;
        for (int a = 0; a < 32; a++) begin
            r_addr1 = 5'(a);
            #1;
            if (hazard1) hz++;
        end
        check("mrst_hazards", 32'(hz), 32'd0);
        @(posedge CLK); #1;
        RST_N = 1'b1;
        cycle();

        // Randomized phase against the reference model
        for (int n = 0; n < 400; n++) begin
            exception  = ($urandom_range(0, 7) == 0);
            iss_valid  = $urandom_range(0, 1);
            iss_rd     = 5'($urandom_range(0, 31));
            alu_valid  = ($urandom_range(0, 1) == 0);
            alu_rd     = 5'($urandom_range(0, 31));
            alu_data   = $urandom;
            ld_valid   = ($urandom_range(0, 2) != 0);
            ld_rd      = 5'($urandom_range(0, 31));
            ld_funct3  = 3'($urandom_range(0, 7));
            ld_addr_lo = 2'($urandom_range(0, 3));
            ld_data    = $urandom;
            r_addr1    = 5'($urandom_range(0, 31));
            r_addr2    = 5'($urandom_range(0, 31));
            cycle();
        end
        idle_inputs();
        for (int n = 0; n < 4; n++) cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
